// File: rtl/conversion_pkg.sv
// Shared types and line constants for the conversion frame scheduler.
package conversion_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/line_encoder.sv
// Differential-style line encoder: out = raw ^ e, e advances by e ^ ~raw each frame bit.
module line_encoder (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  input  logic raw,
  output logic line_out
);

  logic e;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= 1'b0;
    end else if (clear) begin
      e <= 1'b0;
    end else if (!hold) begin
      e <= e ^ ~raw;
    end
  end

  assign line_out = raw ^ e;

endmodule

// File: rtl/conversion_frame_scheduler.sv
// Two-requester round-robin frame scheduler: grants a payload, serialises
// START/DATA/STOP bits through the line encoder.
module conversion_frame_scheduler
  import conversion_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              line_out,
  output logic              line_active,
  output logic              grant_id,
  output logic              frame_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic              rr_last;
  logic              winner;
  logic              grant;
  logic              raw;

  // Both valid: alternate away from the last grantee; otherwise the lone requester wins.
  assign winner = (&req_valid) ? ~rr_last : ~req_valid[0];
  // rst_n gates the handshake so no accept pulse is seen while held in reset.
  assign grant  = rst_n && (state == IDLE) && enable && (|req_valid);

  assign req_ready   = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign line_active = (state != IDLE);
  assign frame_done  = (state == STOP);

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    raw = 1'b0;
    unique case (state)
      START:   raw = START_BIT;
      DATA:    raw = shift_q[DATA_W-1];
      STOP:    raw = STOP_BIT;
      default: raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      rr_last  <= 1'b1;
      grant_id <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            shift_q  <= winner ? req_data1 : req_data0;
            grant_id <= winner;
            rr_last  <= winner;
            bit_cnt  <= '0;
            state    <= START;
          end
        end
        START: state <= DATA;
        DATA: begin
          shift_q <= shift_q << 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Clearing in STOP as well as on grant keeps e at 0 throughout IDLE.
  line_encoder u_line_encoder (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (grant || (state == STOP)),
    .hold     (state == IDLE),
    .raw      (raw),
    .line_out (line_out)
  );

endmodule

// File: tb/tb_conversion_frame_scheduler.sv
// Scoreboard bench: a cycle-level reference model predicts grants and encoded
// frames; an independent monitor collects DUT frames and compares.
module tb_conversion_frame_scheduler;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [1:0]    req_valid;
  logic [DW-1:0] req_data0;
  logic [DW-1:0] req_data1;
  logic [1:0]    req_ready;
  logic          line_out;
  logic          line_active;
  logic          grant_id;
  logic          frame_done;

  conversion_frame_scheduler #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data0   (req_data0),
    .req_data1   (req_data1),
    .req_ready   (req_ready),
    .line_out    (line_out),
    .line_active (line_active),
    .grant_id    (grant_id),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          id;
    logic [DW+1:0] bits;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];

  // Line sequence for one frame, first bit in the MSB position.
  function automatic logic [DW+1:0] encode(input logic [DW-1:0] d);
    logic [DW+1:0] fr;
    logic [DW+1:0] out;
    logic e;
    fr  = {1'b1, d, 1'b0};
    out = '0;
    e   = 1'b0;
    for (int i = DW + 1; i >= 0; i--) begin
      out[i] = fr[i] ^ e;
      e      = e ^ ~fr[i];
    end
    return out;
  endfunction

  // Reference model: a requester may be granted once DW+3 cycles have elapsed since the last grant.
  int   m_busy = 0;
  logic m_last = 1'b1;
  logic m_w;
  exp_t m_e;

  initial begin : model
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0;
        m_last = 1'b1;
        sb_q.delete();
      end else begin
        if (m_busy > 0) m_busy--;
        if (m_busy == 0 && enable && req_valid != 2'b00) begin
          m_w      = (req_valid == 2'b11) ? ~m_last : req_valid[1];
          m_e.id   = m_w;
          m_e.bits = encode(m_w ? req_data1 : req_data0);
          m_e.cyc  = cyc;
          sb_q.push_back(m_e);
          m_last = m_w;
          m_busy = DW + 3;
        end
      end
    end
  end

  logic          in_frame = 1'b0;
  int            pos      = 0;
  logic          mon_id;
  int            mon_cyc;
  logic [DW+1:0] got;
  exp_t          mon_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        in_frame = 1'b0;
        continue;
      end
      if (!in_frame) begin
        check("idle_line_active", line_active, 0);
        check("idle_line_out", line_out, 0);
        check("idle_frame_done", frame_done, 0);
        if (req_ready != 2'b00) begin
          check("ready_onehot", $countones(req_ready), 1);
          mon_id   = req_ready[1];
          mon_cyc  = cyc;
          in_frame = 1'b1;
          pos      = 0;
          got      = '0;
        end
      end else begin
        pos++;
        check("frame_line_active", line_active, 1);
        check("frame_ready_low", req_ready, 0);
        check("frame_grant_id", grant_id, mon_id);
        check("frame_done_pulse", frame_done, (pos == DW + 2));
        got[DW + 2 - pos] = line_out;
        if (pos == DW + 2) begin
          in_frame = 1'b0;
          check("sb_has_entry", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("frame_requester", mon_id, mon_e.id);
            check("grant_cycle", mon_cyc, mon_e.cyc);
            check("line_bits", got, mon_e.bits);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(output logic [1:0] seen);
    seen = 2'b00;
    for (int i = 0; i < 60 && seen == 2'b00; i++) begin
      @(negedge clk);
      #2;
      seen = req_ready;
    end
    check("grant_seen", (seen != 2'b00), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] seen;

  initial begin : stimulus
    rst_n     = 1'b1;
    enable    = 1'b1;
    req_valid = 2'b11;
    req_data0 = '0;
    req_data1 = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_line_out", line_out, 0);
    check("rst_line_active", line_active, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_grant_id", grant_id, 0);

    // Single requester 0 with A5; payload changes right after the grant.
    step(2);
    req_valid = 2'b01;
    req_data0 = 8'hA5;
    rst_n     = 1'b1;
    step(1);
    req_valid = 2'b00;
    for (int i = 0; i < 15; i++) begin
      req_data0 = DW'($urandom);
      step(1);
    end

    // Both valid continuously: alternating grants 11 cycles apart.
    req_data0 = 8'h00;
    req_data1 = 8'hFF;
    req_valid = 2'b11;
    step(50);

    // Only requester 1.
    req_valid = 2'b10;
    step(40);

    // Enable dropped in the 4th DATA cycle of a frame.
    req_valid = 2'b11;
    wait_grant(seen);
    repeat (5) @(posedge clk);
    #1 enable = 1'b0;
    step(20);
    enable = 1'b1;
    step(1);

    // Reset in the 5th DATA cycle of a requester-0 frame.
    seen = 2'b00;
    for (int k = 0; k < 4 && seen != 2'b01; k++) wait_grant(seen);
    check("pre_reset_req0_grant", seen, 2'b01);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_line_active", line_active, 0);
    check("async_rst_line_out", line_out, 0);
    check("async_rst_frame_done", frame_done, 0);
    check("async_rst_req_ready", req_ready, 0);
    check("async_rst_grant_id", grant_id, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_grant(seen);
    check("post_reset_grant", seen, 2'b01);

    // Randomised traffic with per-cycle payload churn.
    for (int i = 0; i < 400; i++) begin
      step(1);
      req_valid = 2'($urandom_range(0, 3));
      enable    = ($urandom_range(0, 9) != 0);
      req_data0 = DW'($urandom);
      req_data1 = DW'($urandom);
    end

    step(1);
    req_valid = 2'b00;
    enable    = 1'b1;
    step(15);
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conversion_frame_scheduler.md
CONVERSION_FRAME_SCHEDULER -- requirements
Module: conversion_frame_scheduler

Interface
REQ-001 Parameter DATA_W, 8, payload width in bits per frame (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  when 0, no new grants are issued; a frame in progress completes.
REQ-005 req_valid  input  2  per-requester frame request; bit i belongs to requester i.
REQ-006 req_data0  input  DATA_W  payload of requester 0, sampled on its grant cycle.
REQ-007 req_data1  input  DATA_W  payload of requester 1, sampled on its grant cycle.
REQ-008 req_ready  output  2  one-hot, one-cycle grant/accept pulse; at most one bit set.
REQ-009 line_out  output  1  encoded serial line bit.
REQ-010 line_active  output  1  high while a frame bit is driven on line_out.
REQ-011 grant_id  output  1  requester index of the frame currently or last transmitted.
REQ-012 frame_done  output  1  one-cycle pulse in the STOP-bit cycle of each completed frame.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP; raw bit is 1 in START, shift-register MSB in DATA, 0 in STOP.
REQ-014 IDLE: if enable=1 and any req_valid=1, the block SHALL pulse req_ready for the winner, capture its data into the shift register, set grant_id, and go to START.
REQ-015 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; the pointer resets to "last granted = 1" (requester 0 wins first).
REQ-016 A single valid requester SHALL be granted regardless of pointer.
REQ-017 START SHALL last 1 cycle, DATA exactly DATA_W cycles (MSB first, left shift per cycle), STOP 1 cycle, then IDLE.
REQ-018 Minimum frame-to-frame period SHALL be DATA_W+3 cycles (grant cycle included); back-to-back grants occur in the IDLE cycle right after STOP.
REQ-019 Encoder state e SHALL be cleared to 0 on the grant cycle; in START/DATA/STOP line_out = raw XOR e and e_next = e XOR NOT raw.
REQ-020 In IDLE line_out SHALL be 0, line_active 0, e held at 0.
REQ-021 line_out and line_active SHALL depend only on registered state, never combinationally on inputs.
REQ-022 req_valid deasserted after grant SHALL NOT affect the frame in progress; req_data changes after the grant cycle SHALL be ignored.
REQ-023 enable falling mid-frame SHALL NOT truncate the frame; the next IDLE issues no grant while enable=0.

Reset
REQ-024 On rst_n=0, immediately and asynchronously: state IDLE, req_ready 0, line_out 0, line_active 0, frame_done 0, grant_id 0, e 0, shift register 0, bit counter 0, RR pointer = 1.
REQ-025 Reset during a frame SHALL abort it with no frame_done pulse; the first grant after release follows REQ-015.

Structure
REQ-026 Shared package conversion_pkg SHALL hold the FSM state enum, START_BIT=1, STOP_BIT=0.
REQ-027 The encoder (e register, XOR output, clear input, hold input) SHALL be a sub-module line_encoder; arbiter, counter and shifter stay in the top.

Verification
REQ-028 Reset, req_valid=2'b01, req_data0=8'hA5 -> req_ready=01 one cycle; line_out over the 10 frame cycles = 1,1,0,0,1,0,0,1,1,0; frame_done in 10th; line_active high exactly 10 cycles.
REQ-029 Both valid continuously, data0=8'h00, data1=8'hFF -> grants alternate 0,1,0,1 with grant_id matching; grants 11 cycles apart.
REQ-030 Only req_valid[1] held -> requester 1 granted every 11 cycles; req_ready[0] never set.
REQ-031 enable dropped in 4th DATA cycle with both valid -> frame completes with frame_done; no grant until enable=1, then next grant same or following cycle.
REQ-032 rst_n pulsed low in 5th DATA cycle -> outputs 0 asynchronously, no frame_done; after release, both valid -> requester 0 granted.
REQ-033 req_data0 changed every cycle after grant -> transmitted payload equals grant-cycle value.
